// File: rtl/src_mem_port.sv
// CPU-side memory port: MAR/MDR registers on a shared tristate bus, issuing
// single read/write requests with alignment checking and an ack timeout.
module src_mem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] cpu_bus,
  input  logic        mar_in,
  input  logic        mdr_in,
  input  logic        mdr_out,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Last counter value at which an ack can still complete the transaction.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [31:0] mar_r, mar_s;
  logic [31:0] mdr_r, mdr_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        err_s;

  assign cpu_bus   = mdr_out ? mdr_r : 32'bz;
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;

  // Next-state, register-load and error-flag decisions.
  always_comb begin
    state_s = state_r;
    mar_s   = mar_r;
    mdr_s   = mdr_r;
    cnt_s   = cnt_r;
    err_s   = err;
    case (state_r)
      IDLE: begin
        if (mar_in) mar_s = cpu_bus;
        else        mar_s = mar_r;
        if (mdr_in) mdr_s = cpu_bus;
        else        mdr_s = mdr_r;
        if (read && write) begin
          err_s = 1'b1;
        end else if (read || write) begin
          if (mar_s[1:0] != 2'b00) begin
            err_s = 1'b1;
          end else begin
            state_s = read ? RD : WR;
            cnt_s   = 8'd0;
            err_s   = 1'b0;
          end
        end else begin
          err_s = err;
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          if (state_r == RD) mdr_s = mem_rdata;
          else               mdr_s = mdr_r;
          state_s = FIN;
        end else if (cnt_r == TO_LAST) begin
          // Timed out: abandon without touching MDR and without a done pulse.
          state_s = IDLE;
          err_s   = 1'b1;
          cnt_s   = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      mar_r   <= 32'd0;
      mdr_r   <= 32'd0;
      cnt_r   <= 8'd0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      mar_r   <= mar_s;
      mdr_r   <= mdr_s;
      cnt_r   <= cnt_s;
      mem_req <= (state_s == RD) || (state_s == WR);
      mem_we  <= (state_s == WR);
      busy    <= (state_s == RD) || (state_s == WR);
      done    <= (state_s == FIN);
      err     <= err_s;
    end
  end

endmodule

// File: tb/tb_src_mem_port.sv
// Bench for src_mem_port: directed transaction table, hand-built corner
// sequences and random transactions checked against a transaction-level model.
module tb_src_mem_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mar_in = 1'b0, mdr_in = 1'b0, mdr_out = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic        busy, done, err;
  logic        bus_en = 1'b0;
  logic [31:0] bus_val = 32'd0;
  wire  [31:0] cpu_bus;

  int checks = 0;
  int errors = 0;

  assign cpu_bus = bus_en ? bus_val : 32'bz;

  src_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_bus(cpu_bus),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .read(read), .write(write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;       // bit0 = read, bit1 = write
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] rdata;
    int          delay;    // ack in this request cycle (1 = first)
    int          exp_req;  // cycles mem_req stays high
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_mdr;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic load_mar(input logic [31:0] v);
    bus_val = v; bus_en = 1'b1; mar_in = 1'b1;
    tick();
    mar_in = 1'b0; bus_en = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_val = v; bus_en = 1'b1; mdr_in = 1'b1;
    tick();
    mdr_in = 1'b0; bus_en = 1'b0;
  endtask

  task automatic chk_mdr(input string nm, input logic [31:0] exp);
    mdr_out = 1'b1;
    #1;
    chk(nm, cpu_bus, exp);
    mdr_out = 1'b0;
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int reqcyc;
    reqcyc = 0;
    load_mar(v.mar);
    load_mdr(v.mdr);
    read = v.op[0]; write = v.op[1];
    tick();
    read = 1'b0; write = 1'b0;
    while (mem_req && reqcyc < 300) begin
      reqcyc++;
      chk({v.name, " addr"},  mem_addr, v.mar);
      chk({v.name, " we"},    {31'd0, mem_we}, {31'd0, v.op == 2'd2});
      chk({v.name, " wdata"}, mem_wdata, v.mdr);
      chk({v.name, " busy"},  {31'd0, busy}, 32'd1);
      if (reqcyc == v.delay) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end
      tick();
      mem_ack = 1'b0;
    end
    chk({v.name, " req_cycles"}, reqcyc, v.exp_req);
    chk({v.name, " done"}, {31'd0, done}, {31'd0, v.exp_done});
    chk({v.name, " err"},  {31'd0, err},  {31'd0, v.exp_err});
    chk({v.name, " busy_end"}, {31'd0, busy}, 32'd0);
    tick();
    chk({v.name, " done_once"}, {31'd0, done}, 32'd0);
    // A stray ack with no request outstanding must change nothing.
    mem_ack = 1'b1; mem_rdata = ~v.exp_mdr;
    tick();
    mem_ack = 1'b0;
    chk({v.name, " stray_req"}, {31'd0, mem_req}, 32'd0);
    chk({v.name, " err_hold"}, {31'd0, err}, {31'd0, v.exp_err});
    chk_mdr({v.name, " mdr"}, v.exp_mdr);
  endtask

  // Transaction-level reference: outcome follows from op legality and ack delay.
  function automatic vec_t model(input logic [1:0] op, input logic [31:0] mar,
                                 input logic [31:0] mdr, input logic [31:0] rdata,
                                 input int delay);
    vec_t v;
    bit legal, ok;
    legal = (op == 2'd1 || op == 2'd2) && (mar % 4 == 0);
    ok    = legal && (delay <= TIMEOUT);
    v.name = "rand"; v.op = op; v.mar = mar; v.mdr = mdr; v.rdata = rdata; v.delay = delay;
    v.exp_req  = !legal ? 0 : (ok ? delay : TIMEOUT);
    v.exp_done = ok;
    v.exp_err  = !ok;
    v.exp_mdr  = (ok && op == 2'd1) ? rdata : mdr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"rd_3wait",   2'd1, 32'h100, 32'h0,        32'hDEADBEEF, 3,  3,  1'b1, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{"wr_fast",    2'd2, 32'h40,  32'h12345678, 32'h0,        1,  1,  1'b1, 1'b0, 32'h12345678});
    tbl.push_back('{"rd_timeout", 2'd1, 32'h104, 32'h11111111, 32'hCAFEF00D, 99, 16, 1'b0, 1'b1, 32'h11111111});
    tbl.push_back('{"rd_clr_err", 2'd1, 32'h108, 32'h2,        32'h0BADF00D, 2,  2,  1'b1, 1'b0, 32'h0BADF00D});
    tbl.push_back('{"rd_misal",   2'd1, 32'h102, 32'h3,        32'h5,        1,  0,  1'b0, 1'b1, 32'h3});
    tbl.push_back('{"rd_wr_both", 2'd3, 32'h100, 32'h4,        32'h6,        1,  0,  1'b0, 1'b1, 32'h4});
    tbl.push_back('{"wr_ack_lim", 2'd2, 32'h10,  32'h7,        32'h0,        16, 16, 1'b1, 1'b0, 32'h7});
    tbl.push_back('{"rd_ack_late",2'd1, 32'h14,  32'h8,        32'h9,        17, 16, 1'b0, 1'b1, 32'h8});
    tbl.push_back('{"wr_misal",   2'd2, 32'h13,  32'h9,        32'h0,        1,  0,  1'b0, 1'b1, 32'h9});

    // Reset state, observed while reset is still asserted.
    #2;
    chk("rst_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk_mdr("rst_mdr", 32'd0);
    #10 rst = 1'b0;
    tick();

    foreach (tbl[i]) run_txn(tbl[i]);

    // Busy lockout: MAR/strobes ignored while a read is outstanding.
    load_mar(32'h100);
    read = 1'b1; tick(); read = 1'b0;
    bus_val = 32'h200; bus_en = 1'b1; mar_in = 1'b1; write = 1'b1;
    tick();
    mar_in = 1'b0; write = 1'b0; bus_en = 1'b0;
    chk("lock_addr", mem_addr, 32'h100);
    chk("lock_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hABCD0123; tick(); mem_ack = 1'b0;
    chk("lock_done", {31'd0, done}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lock_no_second_req", {31'd0, mem_req}, 32'd0);
    end
    chk("lock_mar_kept", mem_addr, 32'h100);
    chk_mdr("lock_mdr", 32'hABCD0123);

    // MDR load and read strobe in the same cycle.
    load_mar(32'h8);
    bus_val = 32'hAAAA5555; bus_en = 1'b1; mdr_in = 1'b1; read = 1'b1;
    tick();
    mdr_in = 1'b0; read = 1'b0; bus_en = 1'b0;
    chk("ldrd_req", {31'd0, mem_req}, 32'd1);
    chk_mdr("ldrd_mdr_busy", 32'hAAAA5555);
    mem_ack = 1'b1; mem_rdata = 32'h13572468; tick(); mem_ack = 1'b0;
    chk("ldrd_done", {31'd0, done}, 32'd1);
    tick();
    chk_mdr("ldrd_mdr", 32'h13572468);

    // Reset in the second wait cycle of a read, then a late ack.
    load_mar(32'h100);
    load_mdr(32'h55);
    read = 1'b1; tick(); read = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_req",  {31'd0, mem_req}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_we",   {31'd0, mem_we}, 32'd0);
    chk("mrst_addr", mem_addr, 32'd0);
    rst = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000; tick(); mem_ack = 1'b0;
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_req2", {31'd0, mem_req}, 32'd0);
    tick();
    chk("mrst_done2", {31'd0, done}, 32'd0);
    chk_mdr("mrst_mdr", 32'd0);

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] mar;
      op  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
      mar = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) mar[1:0] = 2'($urandom_range(1, 3));
      run_txn(model(op, mar, $urandom, $urandom, $urandom_range(1, TIMEOUT + 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
